// File: rtl/mem_access_arbiter_if.sv
// Memory-side access port: the arbiter drives the command half (master modport),
// the memory drives busy flags, next serials and tagged responses (slave modport).
interface mem_access_arbiter_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 128,
  parameter int SERIAL_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0]   memAccessAddr;
  logic [DATA_WIDTH-1:0]   memAccessWriteData;
  logic                    memAccessRE;
  logic                    memAccessWE;
  logic                    memAccessReadBusy;
  logic                    memAccessWriteBusy;
  logic [SERIAL_WIDTH-1:0] nextMemReadSerial;
  logic [SERIAL_WIDTH-1:0] nextMemWriteSerial;
  logic                    memReadDataReady;
  logic [DATA_WIDTH-1:0]   memReadData;
  logic [SERIAL_WIDTH-1:0] memReadSerial;
  logic                    memWriteAckValid;
  logic [SERIAL_WIDTH-1:0] memWriteAckSerial;

  modport master (
    output memAccessAddr, memAccessWriteData, memAccessRE, memAccessWE,
    input  memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
    input  memReadDataReady, memReadData, memReadSerial, memWriteAckValid, memWriteAckSerial
  );

  modport slave (
    input  memAccessAddr, memAccessWriteData, memAccessRE, memAccessWE,
    output memAccessReadBusy, memAccessWriteBusy, nextMemReadSerial, nextMemWriteSerial,
    output memReadDataReady, memReadData, memReadSerial, memWriteAckValid, memWriteAckSerial
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// N-master arbiter in front of the single memory access port: combinational grant/command
// path, serial-tagged owner tables that route registered read data and write acks back.
module mem_access_arbiter_chk #(
  parameter int NUM_MASTERS = 2
) (
  input logic                   clk,
  input logic                   rst,
  input logic [NUM_MASTERS-1:0] reqRE,
  input logic [NUM_MASTERS-1:0] reqWE
);
  // A master raising read and write together is served as a write; flag it in simulation.
  a_no_rd_wr_same_master: assert property (@(posedge clk) disable iff (rst)
    ((reqRE & reqWE) == '0));
endmodule

module mem_access_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 128,
  parameter int SERIAL_WIDTH = 4,
  parameter int ARB_MODE     = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              exclusive,
  input  logic [NUM_MASTERS-1:0]            reqRE,
  input  logic [NUM_MASTERS-1:0]            reqWE,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] reqAddr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] reqWriteData,
  output logic [NUM_MASTERS-1:0]            reqGrant,
  mem_access_arbiter_if.master              mem,
  output logic [NUM_MASTERS-1:0]            respReadValid,
  output logic [DATA_WIDTH-1:0]             respReadData,
  output logic [NUM_MASTERS-1:0]            respWriteAck,
  output logic [SERIAL_WIDTH:0]             outstandingReads,
  output logic                              errSpurious
);
  localparam int N    = NUM_MASTERS;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int TAGS = 2 ** SERIAL_WIDTH;
  localparam logic [SERIAL_WIDTH:0] CNT_FULL = (SERIAL_WIDTH + 1)'(TAGS);

  logic [TAGS-1:0]          rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic [TAGS-1:0][IW-1:0]  rd_owner_q, rd_owner_d, wr_owner_q, wr_owner_d;
  logic [SERIAL_WIDTH:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [N-1:0]             resp_rd_valid_q, resp_rd_valid_d, resp_wr_ack_q, resp_wr_ack_d;
  logic [DATA_WIDTH-1:0]    resp_rd_data_q, resp_rd_data_d;
  logic                     err_q, err_d;

  logic                     rd_blocked_s, wr_blocked_s;
  logic [N-1:0]             elig_s;
  logic                     grant_any_s, grant_rd_s, grant_wr_s;
  logic [IW-1:0]            grant_idx_s;
  logic                     rd_hit_s, wr_hit_s;

  // A serial slot is reusable only once its previous owner has retired.
  always_comb begin
    rd_blocked_s = mem.memAccessReadBusy || (rd_cnt_q == CNT_FULL)
                   || rd_valid_q[mem.nextMemReadSerial];
    wr_blocked_s = mem.memAccessWriteBusy || (wr_cnt_q == CNT_FULL)
                   || wr_valid_q[mem.nextMemWriteSerial];
    for (int i = 0; i < N; i++) begin
      elig_s[i] = !rst && (!exclusive || (i == 0))
                  && ((reqWE[i] && !wr_blocked_s) || (!reqWE[i] && reqRE[i] && !rd_blocked_s));
    end
  end

  // Descending scans let the lowest qualifying index win; RR's second scan (above the
  // pointer) overrides the wrap-around scan.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    if (ARB_MODE == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (elig_s[i]) begin
          grant_any_s = 1'b1;
          grant_idx_s = IW'(i);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (elig_s[i] && (IW'(i) <= rr_ptr_q)) begin
          grant_any_s = 1'b1;
          grant_idx_s = IW'(i);
        end
      end
      for (int i = N - 1; i >= 0; i--) begin
        if (elig_s[i] && (IW'(i) > rr_ptr_q)) begin
          grant_any_s = 1'b1;
          grant_idx_s = IW'(i);
        end
      end
    end
    grant_wr_s = grant_any_s && reqWE[grant_idx_s];
    grant_rd_s = grant_any_s && !reqWE[grant_idx_s];
  end

  // Command path: granted master's request straight onto the memory port.
  always_comb begin
    reqGrant               = '0;
    mem.memAccessAddr      = '0;
    mem.memAccessWriteData = '0;
    mem.memAccessRE        = 1'b0;
    mem.memAccessWE        = 1'b0;
    if (grant_any_s) begin
      reqGrant[grant_idx_s]  = 1'b1;
      mem.memAccessAddr      = reqAddr[int'(grant_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
      mem.memAccessWriteData = reqWriteData[int'(grant_idx_s) * DATA_WIDTH +: DATA_WIDTH];
      mem.memAccessRE        = grant_rd_s;
      mem.memAccessWE        = grant_wr_s;
    end else begin
      reqGrant = '0;
    end
  end

  // Retire responses first, then allocate new grants, so a same-serial reuse lands valid.
  always_comb begin
    rd_hit_s        = mem.memReadDataReady && rd_valid_q[mem.memReadSerial];
    wr_hit_s        = mem.memWriteAckValid && wr_valid_q[mem.memWriteAckSerial];
    rd_valid_d      = rd_valid_q;
    rd_owner_d      = rd_owner_q;
    wr_valid_d      = wr_valid_q;
    wr_owner_d      = wr_owner_q;
    resp_rd_valid_d = '0;
    resp_wr_ack_d   = '0;
    resp_rd_data_d  = resp_rd_data_q;
    err_d           = err_q || (mem.memReadDataReady && !rd_hit_s)
                            || (mem.memWriteAckValid && !wr_hit_s);
    if (rd_hit_s) begin
      rd_valid_d[mem.memReadSerial]                  = 1'b0;
      resp_rd_valid_d[rd_owner_q[mem.memReadSerial]] = 1'b1;
      resp_rd_data_d                                 = mem.memReadData;
    end else begin
      resp_rd_valid_d = '0;
    end
    if (wr_hit_s) begin
      wr_valid_d[mem.memWriteAckSerial]                = 1'b0;
      resp_wr_ack_d[wr_owner_q[mem.memWriteAckSerial]] = 1'b1;
    end else begin
      resp_wr_ack_d = '0;
    end
    if (grant_rd_s) begin
      rd_valid_d[mem.nextMemReadSerial] = 1'b1;
      rd_owner_d[mem.nextMemReadSerial] = grant_idx_s;
    end else begin
      rd_valid_d = rd_valid_d;
    end
    if (grant_wr_s) begin
      wr_valid_d[mem.nextMemWriteSerial] = 1'b1;
      wr_owner_d[mem.nextMemWriteSerial] = grant_idx_s;
    end else begin
      wr_valid_d = wr_valid_d;
    end
    rd_cnt_d = rd_cnt_q + (SERIAL_WIDTH + 1)'(grant_rd_s) - (SERIAL_WIDTH + 1)'(rd_hit_s);
    wr_cnt_d = wr_cnt_q + (SERIAL_WIDTH + 1)'(grant_wr_s) - (SERIAL_WIDTH + 1)'(wr_hit_s);
    rr_ptr_d = grant_any_s ? grant_idx_s : rr_ptr_q;
  end

  // State registers; pointer resets to N-1 so master 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q      <= '0;
      rd_owner_q      <= '0;
      wr_valid_q      <= '0;
      wr_owner_q      <= '0;
      rd_cnt_q        <= '0;
      wr_cnt_q        <= '0;
      rr_ptr_q        <= IW'(N - 1);
      resp_rd_valid_q <= '0;
      resp_wr_ack_q   <= '0;
      resp_rd_data_q  <= '0;
      err_q           <= 1'b0;
    end else begin
      rd_valid_q      <= rd_valid_d;
      rd_owner_q      <= rd_owner_d;
      wr_valid_q      <= wr_valid_d;
      wr_owner_q      <= wr_owner_d;
      rd_cnt_q        <= rd_cnt_d;
      wr_cnt_q        <= wr_cnt_d;
      rr_ptr_q        <= rr_ptr_d;
      resp_rd_valid_q <= resp_rd_valid_d;
      resp_wr_ack_q   <= resp_wr_ack_d;
      resp_rd_data_q  <= resp_rd_data_d;
      err_q           <= err_d;
    end
  end

  assign respReadValid    = resp_rd_valid_q;
  assign respReadData     = resp_rd_data_q;
  assign respWriteAck     = resp_wr_ack_q;
  assign outstandingReads = rd_cnt_q;
  assign errSpurious      = err_q;

  mem_access_arbiter_chk #(.NUM_MASTERS(N)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .reqRE (reqRE),
    .reqWE (reqWE)
  );
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench: a 2-master fixed-priority arbiter and a 3-master round-robin arbiter
// with a 4-tag serial space, memory side driven by hand.
module tb_mem_access_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // fixed-priority instance: N=2, SW=4
  logic        fx_rst, fx_excl;
  logic [1:0]  fx_re, fx_we, fx_grant, fx_rvalid, fx_wack;
  logic [31:0] fx_addr;
  logic [63:0] fx_wdata;
  logic [31:0] fx_rdata;
  logic [4:0]  fx_outs;
  logic        fx_err;
  mem_access_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .SERIAL_WIDTH(4)) fx_if ();

  mem_access_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(16), .DATA_WIDTH(32),
                       .SERIAL_WIDTH(4), .ARB_MODE(0)) u_fx (
    .clk(clk), .rst(fx_rst), .exclusive(fx_excl), .reqRE(fx_re), .reqWE(fx_we),
    .reqAddr(fx_addr), .reqWriteData(fx_wdata), .reqGrant(fx_grant), .mem(fx_if.master),
    .respReadValid(fx_rvalid), .respReadData(fx_rdata), .respWriteAck(fx_wack),
    .outstandingReads(fx_outs), .errSpurious(fx_err)
  );

  // round-robin instance: N=3, SW=2
  logic        rr_rst, rr_excl;
  logic [2:0]  rr_re, rr_we, rr_grant, rr_rvalid, rr_wack;
  logic [47:0] rr_addr;
  logic [95:0] rr_wdata;
  logic [31:0] rr_rdata;
  logic [2:0]  rr_outs;
  logic        rr_err;
  mem_access_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .SERIAL_WIDTH(2)) rr_if ();

  mem_access_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(16), .DATA_WIDTH(32),
                       .SERIAL_WIDTH(2), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rr_rst), .exclusive(rr_excl), .reqRE(rr_re), .reqWE(rr_we),
    .reqAddr(rr_addr), .reqWriteData(rr_wdata), .reqGrant(rr_grant), .mem(rr_if.master),
    .respReadValid(rr_rvalid), .respReadData(rr_rdata), .respWriteAck(rr_wack),
    .outstandingReads(rr_outs), .errSpurious(rr_err)
  );

  logic [2:0] exp_wr_grant [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0] ack_serial   [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
  logic [2:0] exp_ack      [4] = '{3'b100, 3'b001, 3'b001, 3'b010};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fx_rst = 1'b1; fx_excl = 1'b0; fx_re = '0; fx_we = '0;
    fx_addr = {16'h2000, 16'h1000}; fx_wdata = {32'hDEAD_BEEF, 32'h1234_5678};
    rr_rst = 1'b1; rr_excl = 1'b0; rr_re = '0; rr_we = '0;
    rr_addr = {16'h0300, 16'h0200, 16'h0100}; rr_wdata = '0;
    fx_if.memAccessReadBusy = 1'b0; fx_if.memAccessWriteBusy = 1'b0;
    fx_if.nextMemReadSerial = '0; fx_if.nextMemWriteSerial = '0;
    fx_if.memReadDataReady = 1'b0; fx_if.memReadData = '0; fx_if.memReadSerial = '0;
    fx_if.memWriteAckValid = 1'b0; fx_if.memWriteAckSerial = '0;
    rr_if.memAccessReadBusy = 1'b0; rr_if.memAccessWriteBusy = 1'b0;
    rr_if.nextMemReadSerial = '0; rr_if.nextMemWriteSerial = '0;
    rr_if.memReadDataReady = 1'b0; rr_if.memReadData = '0; rr_if.memReadSerial = '0;
    rr_if.memWriteAckValid = 1'b0; rr_if.memWriteAckSerial = '0;
    tick(); tick();

    // reset state, requests present but suppressed
    fx_re = 2'b11; #2;
    chk("rst_fx_grant", fx_grant, 2'b00);
    chk("rst_fx_re", fx_if.memAccessRE, 1'b0);
    chk("rst_fx_outs", fx_outs, 5'd0);
    chk("rst_fx_err", fx_err, 1'b0);
    chk("rst_rr_outs", rr_outs, 3'd0);
    chk("rst_rr_rvalid", rr_rvalid, 3'b000);
    tick();
    fx_rst = 1'b0; rr_rst = 1'b0; fx_re = 2'b00;
    tick();

    // fixed priority: master 0 always wins, master 1 starved
    fx_re = 2'b11;
    for (int s = 0; s < 3; s++) begin
      fx_if.nextMemReadSerial = 4'(s); #2;
      chk("fx_prio_grant", fx_grant, 2'b01);
      chk("fx_prio_re", fx_if.memAccessRE, 1'b1);
      chk("fx_prio_addr", fx_if.memAccessAddr, 16'h1000);
      tick();
    end
    fx_re = 2'b00;
    chk("fx_outs3", fx_outs, 5'd3);
    for (int s = 0; s < 3; s++) begin
      fx_if.memReadDataReady = 1'b1; fx_if.memReadSerial = 4'(s);
      fx_if.memReadData = 32'hA0 + 32'(s);
      tick();
      chk("fx_rd_route", fx_rvalid, 2'b01);
      chk("fx_rd_data", fx_rdata, 32'hA0 + 32'(s));
    end
    fx_if.memReadDataReady = 1'b0;
    tick();
    chk("fx_rd_pulse", fx_rvalid, 2'b00);
    chk("fx_outs0", fx_outs, 5'd0);

    // master 1 write alone, then ack routed back
    fx_we = 2'b10; fx_if.nextMemWriteSerial = 4'd5; #2;
    chk("fx_wr_grant", fx_grant, 2'b10);
    chk("fx_wr_we", fx_if.memAccessWE, 1'b1);
    chk("fx_wr_re", fx_if.memAccessRE, 1'b0);
    chk("fx_wr_addr", fx_if.memAccessAddr, 16'h2000);
    chk("fx_wr_data", fx_if.memAccessWriteData, 32'hDEAD_BEEF);
    tick();
    fx_we = 2'b00; #2;
    chk("fx_idle_we", fx_if.memAccessWE, 1'b0);
    chk("fx_idle_addr", fx_if.memAccessAddr, 16'h0000);
    fx_if.memWriteAckValid = 1'b1; fx_if.memWriteAckSerial = 4'd5;
    tick();
    fx_if.memWriteAckValid = 1'b0;
    chk("fx_wack", fx_wack, 2'b10);

    // read busy blocks reads
    fx_re = 2'b01; fx_if.memAccessReadBusy = 1'b1; #2;
    chk("fx_busy_grant", fx_grant, 2'b00);
    fx_re = 2'b00; fx_if.memAccessReadBusy = 1'b0;

    // spurious response on serial 3: dropped, sticky error until reset
    fx_if.memReadDataReady = 1'b1; fx_if.memReadSerial = 4'd3;
    tick();
    fx_if.memReadDataReady = 1'b0;
    chk("fx_spur_rvalid", fx_rvalid, 2'b00);
    chk("fx_spur_err", fx_err, 1'b1);
    tick(); tick();
    chk("fx_spur_sticky", fx_err, 1'b1);
    fx_rst = 1'b1; tick(); fx_rst = 1'b0;
    chk("fx_spur_clear", fx_err, 1'b0);

    // round-robin writes from all three masters
    rr_we = 3'b111;
    for (int s = 0; s < 4; s++) begin
      rr_if.nextMemWriteSerial = 2'(s); #2;
      chk("rr_wr_grant", rr_grant, exp_wr_grant[s]);
      tick();
    end
    rr_we = 3'b010; rr_if.nextMemWriteSerial = 2'd0; #2;
    chk("rr_wr_full", rr_grant, 3'b000);
    chk("rr_wr_noreads", rr_outs, 3'd0);
    rr_we = 3'b000;
    for (int k = 0; k < 4; k++) begin
      rr_if.memWriteAckValid = 1'b1; rr_if.memWriteAckSerial = ack_serial[k];
      tick();
      chk("rr_wack_order", rr_wack, exp_ack[k]);
    end
    rr_if.memWriteAckValid = 1'b0;
    tick();
    chk("rr_wack_pulse", rr_wack, 3'b000);

    // exclusive: only master 0; responses survive exclusive dropping
    rr_excl = 1'b1; rr_re = 3'b110; rr_if.nextMemReadSerial = 2'd0; #2;
    chk("rr_excl_block", rr_grant, 3'b000);
    chk("rr_excl_re", rr_if.memAccessRE, 1'b0);
    tick();
    rr_re = 3'b111; #2;
    chk("rr_excl_m0_a", rr_grant, 3'b001);
    tick();
    rr_if.nextMemReadSerial = 2'd1; #2;
    chk("rr_excl_m0_b", rr_grant, 3'b001);
    tick();
    rr_re = 3'b000; rr_excl = 1'b0;
    chk("rr_excl_outs", rr_outs, 3'd2);
    rr_if.memReadDataReady = 1'b1; rr_if.memReadSerial = 2'd1; rr_if.memReadData = 32'h11;
    tick();
    chk("rr_excl_rsp1", rr_rvalid, 3'b001);
    chk("rr_excl_data", rr_rdata, 32'h11);
    rr_if.memReadSerial = 2'd0; rr_if.memReadData = 32'h22;
    tick();
    chk("rr_excl_rsp0", rr_rvalid, 3'b001);
    rr_if.memReadDataReady = 1'b0;
    tick();
    chk("rr_excl_outs0", rr_outs, 3'd0);

    // fill all 4 read serials from master 1, 5th blocked
    rr_re = 3'b010;
    for (int s = 0; s < 4; s++) begin
      rr_if.nextMemReadSerial = 2'(s); #2;
      chk("rr_fill_grant", rr_grant, 3'b010);
      tick();
    end
    chk("rr_full_outs", rr_outs, 3'd4);
    rr_if.nextMemReadSerial = 2'd0; #2;
    chk("rr_5th_block", rr_grant, 3'b000);
    tick();
    chk("rr_5th_outs", rr_outs, 3'd4);
    rr_if.memReadDataReady = 1'b1; rr_if.memReadSerial = 2'd0; #2;
    chk("rr_retire_block", rr_grant, 3'b000);
    tick();
    chk("rr_retire_rvalid", rr_rvalid, 3'b010);
    chk("rr_retire_outs", rr_outs, 3'd3);
    rr_if.memReadSerial = 2'd1; #2;
    chk("rr_same_cyc_grant", rr_grant, 3'b010);
    tick();
    chk("rr_same_cyc_outs", rr_outs, 3'd3);
    chk("rr_same_cyc_rvalid", rr_rvalid, 3'b010);
    rr_if.memReadDataReady = 1'b0; rr_if.nextMemReadSerial = 2'd1; #2;
    chk("rr_refill_grant", rr_grant, 3'b010);
    tick();
    rr_re = 3'b000;
    chk("rr_refill_outs", rr_outs, 3'd4);
    rr_if.memReadDataReady = 1'b1; rr_if.memReadSerial = 2'd2;
    tick();
    rr_if.memReadSerial = 2'd3;
    tick();
    rr_if.memReadDataReady = 1'b0;
    chk("rr_pre_rst_outs", rr_outs, 3'd2);

    // reset with 2 reads in flight
    rr_rst = 1'b1; tick(); rr_rst = 1'b0;
    chk("rr_rst_outs0", rr_outs, 3'd0);
    chk("rr_rst_rvalid0", rr_rvalid, 3'b000);
    chk("rr_rst_rdata0", rr_rdata, 32'h0);
    chk("rr_rst_err0", rr_err, 1'b0);
    rr_re = 3'b111; rr_if.nextMemReadSerial = 2'd0; #2;
    chk("rr_rst_first", rr_grant, 3'b001);
    tick();
    rr_re = 3'b000;
    rr_if.memReadDataReady = 1'b1; rr_if.memReadSerial = 2'd3;
    tick();
    rr_if.memReadDataReady = 1'b0;
    chk("rr_late_rvalid", rr_rvalid, 3'b000);
    chk("rr_late_err", rr_err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
